// File: rtl/dmem_mp.sv
// dmem_mp: multi-port, fixed-latency flop data memory.
// N_PORTS valid/ready request channels are arbitrated round-robin into one
// word array. Every accepted request returns a single-cycle response on its
// own port exactly LATENCY cycles after acceptance.
//
// Ports:
//   i_clk, i_rst_n     clock, synchronous active-low reset
//   i_req_valid        per-port request valid
//   o_req_ready        per-port grant (combinational, one-hot or zero)
//   i_req_addr         per-port byte address, port p at [p*ADDR_W +: ADDR_W]
//   i_req_wren         per-port write enable (1 = write, 0 = read)
//   i_req_wdata        per-port write data
//   i_req_bmask        per-port byte enables
//   o_rsp_valid        per-port response pulse
//   o_rsp_rdata        per-port read data (zero for writes / out-of-range)
//   o_rsp_err          per-port out-of-range flag
module dmem_mp #(
    parameter int unsigned N_PORTS = 2,
    parameter int unsigned ADDR_W  = 18,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned DEPTH   = 1024,
    parameter int unsigned LATENCY = 2
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic [N_PORTS-1:0]            i_req_valid,
    output logic [N_PORTS-1:0]            o_req_ready,
    input  logic [N_PORTS*ADDR_W-1:0]     i_req_addr,
    input  logic [N_PORTS-1:0]            i_req_wren,
    input  logic [N_PORTS*DATA_W-1:0]     i_req_wdata,
    input  logic [N_PORTS*(DATA_W/8)-1:0] i_req_bmask,
    output logic [N_PORTS-1:0]            o_rsp_valid,
    output logic [N_PORTS*DATA_W-1:0]     o_rsp_rdata,
    output logic [N_PORTS-1:0]            o_rsp_err
);

    localparam int unsigned NB     = DATA_W / 8;
    localparam int unsigned LSB_W  = (NB > 1) ? $clog2(NB) : 0;
    localparam int unsigned IDX_W  = ADDR_W - LSB_W;
    localparam int unsigned PTR_W  = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;
    localparam int unsigned MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // Round-robin pointer
    logic [PTR_W-1:0] rr_q, rr_d;

    // Arbitration results and selected request
    logic [N_PORTS-1:0] gnt;
    logic [PTR_W-1:0]   gnt_idx;
    logic               found;
    logic               accept;
    logic [PTR_W-1:0]   arb_p;
    int unsigned        arb_sum;
    int unsigned        rr_nxt;
    logic [ADDR_W-1:0]  sel_addr;
    logic               sel_wren;
    logic [DATA_W-1:0]  sel_wdata;
    logic [NB-1:0]      sel_bmask;

    // Decode
    logic [IDX_W-1:0]   sel_idx;
    logic [MEM_AW-1:0]  mem_idx;
    logic               in_range;
    logic [DATA_W-1:0]  rd_word;
    logic [NB-1:0]      wr_be;
    logic               unused_addr;

    // Storage (not reset)
    logic [DATA_W-1:0]  mem_q [DEPTH];

    // Response pipeline, payload already steered to its port slice
    logic [N_PORTS-1:0]        pv_q [LATENCY];
    logic [N_PORTS-1:0]        pv_d [LATENCY];
    logic [N_PORTS*DATA_W-1:0] pd_q [LATENCY];
    logic [N_PORTS*DATA_W-1:0] pd_d [LATENCY];
    logic [N_PORTS-1:0]        pe_q [LATENCY];
    logic [N_PORTS-1:0]        pe_d [LATENCY];

    // Grant the first valid port at or after rr_q, wrapping modulo N_PORTS
    always_comb begin
        gnt       = '0;
        gnt_idx   = '0;
        found     = 1'b0;
        arb_p     = '0;
        arb_sum   = 0;
        sel_addr  = '0;
        sel_wren  = 1'b0;
        sel_wdata = '0;
        sel_bmask = '0;
        for (int unsigned i = 0; i < N_PORTS; i++) begin
            arb_sum = 32'(rr_q) + i;
            if (arb_sum >= N_PORTS) begin
                arb_sum = arb_sum - N_PORTS;
            end
            arb_p = PTR_W'(arb_sum);
            if (!found && i_req_valid[arb_p]) begin
                found     = 1'b1;
                gnt[arb_p] = 1'b1;
                gnt_idx   = arb_p;
                sel_addr  = i_req_addr[arb_p*ADDR_W +: ADDR_W];
                sel_wren  = i_req_wren[arb_p];
                sel_wdata = i_req_wdata[arb_p*DATA_W +: DATA_W];
                sel_bmask = i_req_bmask[arb_p*NB +: NB];
            end
        end
        // No grants while reset is asserted
        if (!i_rst_n) begin
            gnt   = '0;
            found = 1'b0;
        end
    end

    assign o_req_ready = gnt;
    assign accept      = found;

    // Word index decode; byte-offset bits are intentionally ignored
    always_comb begin
        sel_idx  = sel_addr[ADDR_W-1:LSB_W];
        in_range = ({1'b0, sel_idx} < (IDX_W+1)'(DEPTH));
        mem_idx  = MEM_AW'(sel_idx);
        rd_word  = '0;
        wr_be    = '0;
        if (in_range && !sel_wren) begin
            rd_word = mem_q[mem_idx];
        end
        if (accept && sel_wren && in_range) begin
            wr_be = sel_bmask;
        end
    end

    assign unused_addr = ^sel_addr;

    // Pointer advance past the granted port; holds when idle
    always_comb begin
        rr_d   = rr_q;
        rr_nxt = 0;
        if (accept) begin
            rr_nxt = 32'(gnt_idx) + 1;
            if (rr_nxt >= N_PORTS) begin
                rr_nxt = 0;
            end
            rr_d = PTR_W'(rr_nxt);
        end
    end

    // Pipeline next-state: stage 0 loads the accepted result, others shift
    always_comb begin
        for (int unsigned k = 0; k < LATENCY; k++) begin
            pv_d[k] = '0;
            pd_d[k] = '0;
            pe_d[k] = '0;
        end
        if (accept) begin
            for (int unsigned p = 0; p < N_PORTS; p++) begin
                if (gnt[p]) begin
                    pv_d[0][p]                   = 1'b1;
                    pd_d[0][p*DATA_W +: DATA_W]  = rd_word;
                    pe_d[0][p]                   = ~in_range;
                end
            end
        end
        for (int unsigned k = 1; k < LATENCY; k++) begin
            pv_d[k] = pv_q[k-1];
            pd_d[k] = pd_q[k-1];
            pe_d[k] = pe_q[k-1];
        end
    end

    // Control state and response pipeline
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            rr_q <= '0;
            for (int unsigned k = 0; k < LATENCY; k++) begin
                pv_q[k] <= '0;
                pd_q[k] <= '0;
                pe_q[k] <= '0;
            end
        end else begin
            rr_q <= rr_d;
            for (int unsigned k = 0; k < LATENCY; k++) begin
                pv_q[k] <= pv_d[k];
                pd_q[k] <= pd_d[k];
                pe_q[k] <= pe_d[k];
            end
        end
    end

    // Byte-lane writes; contents survive reset
    always_ff @(posedge i_clk) begin
        for (int unsigned b = 0; b < NB; b++) begin
            if (wr_be[b]) begin
                mem_q[mem_idx][b*8 +: 8] <= sel_wdata[b*8 +: 8];
            end
        end
    end

    assign o_rsp_valid = pv_q[LATENCY-1];
    assign o_rsp_rdata = pd_q[LATENCY-1];
    assign o_rsp_err   = pe_q[LATENCY-1];

endmodule

// File: tb/tb_dmem_mp.sv
// tb_dmem_mp: directed self-checking bench for dmem_mp (2 ports, LATENCY 2).
module tb_dmem_mp;

    localparam int unsigned NP    = 2;
    localparam int unsigned AW    = 18;
    localparam int unsigned DW    = 32;
    localparam int unsigned NB    = DW / 8;
    localparam int unsigned DEPTH = 1024;
    localparam int unsigned LAT   = 2;

    logic                 i_clk = 1'b0;
    logic                 i_rst_n;
    logic [NP-1:0]        i_req_valid;
    logic [NP-1:0]        o_req_ready;
    logic [NP*AW-1:0]     i_req_addr;
    logic [NP-1:0]        i_req_wren;
    logic [NP*DW-1:0]     i_req_wdata;
    logic [NP*NB-1:0]     i_req_bmask;
    logic [NP-1:0]        o_rsp_valid;
    logic [NP*DW-1:0]     o_rsp_rdata;
    logic [NP-1:0]        o_rsp_err;

    int n_checks = 0;
    int n_errors = 0;

    always #5 i_clk = ~i_clk;

    dmem_mp #(
        .N_PORTS (NP),
        .ADDR_W  (AW),
        .DATA_W  (DW),
        .DEPTH   (DEPTH),
        .LATENCY (LAT)
    ) u_dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_req_valid (i_req_valid),
        .o_req_ready (o_req_ready),
        .i_req_addr  (i_req_addr),
        .i_req_wren  (i_req_wren),
        .i_req_wdata (i_req_wdata),
        .i_req_bmask (i_req_bmask),
        .o_rsp_valid (o_rsp_valid),
        .o_rsp_rdata (o_rsp_rdata),
        .o_rsp_err   (o_rsp_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%h expected 0x%h", tag, got, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are sampled
    // on the falling edge.
    task automatic next_cycle();
        @(posedge i_clk);
        #1;
    endtask

    task automatic sample();
        @(negedge i_clk);
    endtask

    task automatic idle_all();
        i_req_valid = '0;
        i_req_wren  = '0;
    endtask

    task automatic set_req(input int p, input logic we, input logic [AW-1:0] a,
                           input logic [DW-1:0] d, input logic [NB-1:0] m);
        i_req_valid[p +: 1]    = 1'b1;
        i_req_wren[p +: 1]     = we;
        i_req_addr[p*AW +: AW] = a;
        i_req_wdata[p*DW +: DW] = d;
        i_req_bmask[p*NB +: NB] = m;
    endtask

    function automatic logic [DW-1:0] rdata_of(input int p);
        return o_rsp_rdata[p*DW +: DW];
    endfunction

    function automatic logic [31:0] onehot(input int p);
        return 32'(1) << p;
    endfunction

    // Single isolated transaction: checks grant, the exact response cycle,
    // its payload, and that the pulse lasts one cycle.
    task automatic xact(input string tag, input int p, input logic we,
                        input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input logic [NB-1:0] m, input logic [DW-1:0] exp_rd,
                        input logic exp_err);
        set_req(p, we, a, d, m);
        sample();
        check({tag, " ready"}, 32'(o_req_ready), onehot(p));
        next_cycle();
        idle_all();
        for (int k = 1; k <= int'(LAT); k++) begin
            sample();
            if (k < int'(LAT)) begin
                check({tag, " early"}, 32'(o_rsp_valid), 32'(0));
            end else begin
                check({tag, " rsp_valid"}, 32'(o_rsp_valid), onehot(p));
                check({tag, " rdata"}, rdata_of(p), exp_rd);
                check({tag, " err"}, 32'(o_rsp_err), exp_err ? onehot(p) : 32'(0));
            end
            next_cycle();
        end
        sample();
        check({tag, " pulse_end"}, 32'(o_rsp_valid), 32'(0));
        next_cycle();
    endtask

    int exp_g [6] = '{0, 1, 0, 1, 0, 1};

    initial begin
        i_rst_n     = 1'b0;
        i_req_valid = '1;
        i_req_addr  = '0;
        i_req_wren  = '0;
        i_req_wdata = '0;
        i_req_bmask = '0;

        // Reset held with all valids high
        sample();
        check("rst ready_first", 32'(o_req_ready), 32'(0));
        for (int c = 0; c < 3; c++) begin
            next_cycle();
            sample();
            check("rst ready", 32'(o_req_ready), 32'(0));
            check("rst rsp_valid", 32'(o_rsp_valid), 32'(0));
            check("rst rsp_err", 32'(o_rsp_err), 32'(0));
            check("rst rdata0", rdata_of(0), 32'(0));
            check("rst rdata1", rdata_of(1), 32'(0));
        end
        next_cycle();
        i_rst_n = 1'b1;
        sample();
        check("rst first_grant", 32'(o_req_ready), 32'b01);
        next_cycle();
        idle_all();
        for (int c = 0; c < 3; c++) next_cycle();

        // Back-to-back write then read on port 0
        set_req(0, 1'b1, 18'h00010, 32'hDEADBEEF, 4'hF);
        sample();
        check("wr ready", 32'(o_req_ready), 32'b01);
        check("wr rsp_idle", 32'(o_rsp_valid), 32'(0));
        next_cycle();
        set_req(0, 1'b0, 18'h00010, 32'h0, 4'h0);
        sample();
        check("rd ready", 32'(o_req_ready), 32'b01);
        check("rd rsp_idle", 32'(o_rsp_valid), 32'(0));
        next_cycle();
        idle_all();
        sample();
        check("wr rsp_valid", 32'(o_rsp_valid), 32'b01);
        check("wr rdata", rdata_of(0), 32'h0);
        check("wr err", 32'(o_rsp_err), 32'(0));
        next_cycle();
        sample();
        check("rd rsp_valid", 32'(o_rsp_valid), 32'b01);
        check("rd rdata", rdata_of(0), 32'hDEADBEEF);
        check("rd err", 32'(o_rsp_err), 32'(0));
        next_cycle();
        sample();
        check("rd pulse_end", 32'(o_rsp_valid), 32'(0));
        next_cycle();

        // Byte-mask merge on port 1
        xact("bm init", 1, 1'b1, 18'h00020, 32'hAABBCCDD, 4'hF, 32'h0, 1'b0);
        xact("bm wr",   1, 1'b1, 18'h00020, 32'h11223344, 4'b0101, 32'h0, 1'b0);
        xact("bm rd",   1, 1'b0, 18'h00020, 32'h0, 4'h0, 32'hAA22CC44, 1'b0);
        xact("bm zero", 1, 1'b1, 18'h00020, 32'hFFFFFFFF, 4'h0, 32'h0, 1'b0);
        xact("bm rd2",  1, 1'b0, 18'h00020, 32'h0, 4'h0, 32'hAA22CC44, 1'b0);

        // Round-robin with both ports reading continuously (pointer at 0)
        set_req(0, 1'b0, 18'h00010, 32'h0, 4'h0);
        set_req(1, 1'b0, 18'h00020, 32'h0, 4'h0);
        for (int c = 0; c < 8; c++) begin
            if (c == 6) idle_all();
            sample();
            if (c < 6) begin
                check("rr grant", 32'(o_req_ready), onehot(exp_g[c]));
            end else begin
                check("rr no_grant", 32'(o_req_ready), 32'(0));
            end
            if (c >= 2) begin
                check("rr rsp_valid", 32'(o_rsp_valid), onehot(exp_g[c-2]));
                check("rr rdata", rdata_of(exp_g[c-2]),
                      (exp_g[c-2] == 0) ? 32'hDEADBEEF : 32'hAA22CC44);
            end else begin
                check("rr rsp_idle", 32'(o_rsp_valid), 32'(0));
            end
            next_cycle();
        end
        sample();
        check("rr drained", 32'(o_rsp_valid), 32'(0));
        next_cycle();

        // Out-of-range boundary
        xact("oor w0",     0, 1'b1, 18'h00000, 32'h0BADF00D, 4'hF, 32'h0, 1'b0);
        xact("oor wlast",  0, 1'b1, 18'h00FFC, 32'hCAFE1234, 4'hF, 32'h0, 1'b0);
        xact("oor wr",     0, 1'b1, 18'h01000, 32'h12345678, 4'hF, 32'h0, 1'b1);
        xact("oor rd0",    0, 1'b0, 18'h00000, 32'h0, 4'h0, 32'h0BADF00D, 1'b0);
        xact("oor rdlast", 1, 1'b0, 18'h00FFC, 32'h0, 4'h0, 32'hCAFE1234, 1'b0);
        xact("oor rd",     1, 1'b0, 18'h01000, 32'h0, 4'h0, 32'h0, 1'b1);
        xact("oor rdmax",  0, 1'b0, 18'h3FFFF, 32'h0, 4'h0, 32'h0, 1'b1);
        xact("unaligned",  0, 1'b0, 18'h00013, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0);

        // Reset one cycle after a read is accepted
        set_req(0, 1'b0, 18'h00020, 32'h0, 4'h0);
        sample();
        check("rif ready", 32'(o_req_ready), 32'b01);
        next_cycle();
        idle_all();
        i_rst_n = 1'b0;
        sample();
        check("rif rsp_t1", 32'(o_rsp_valid), 32'(0));
        next_cycle();
        i_rst_n = 1'b1;
        sample();
        check("rif rsp_t2", 32'(o_rsp_valid), 32'(0));
        next_cycle();
        sample();
        check("rif rsp_t3", 32'(o_rsp_valid), 32'(0));
        next_cycle();
        xact("rif keep1", 1, 1'b0, 18'h00020, 32'h0, 4'h0, 32'hAA22CC44, 1'b0);
        xact("rif keep0", 0, 1'b0, 18'h00010, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/dmem_mp.md
# dmem_mp

Multi-port, fixed-latency data memory for the core's load/store path. It replaces the single-requester flop memory with a block that takes `N_PORTS` independent valid/ready request channels and arbitrates them round-robin into one flop-based word array. Each accepted request produces a one-cycle response pulse exactly `LATENCY` cycles later. It sits behind the LSU and the debug/loader port, and is the simulation/FPGA-fallback path next to the SRAM controller.

## Interface
Parameters:
- `N_PORTS`, 2: number of requester channels (≥1).
- `ADDR_W`, 18: byte-address width per port.
- `DATA_W`, 32: data width. Must be a multiple of 8 and a power of two. `NB = DATA_W/8` byte lanes.
- `DEPTH`, 1024: number of words. Need not be a power of two. Must satisfy `DEPTH ≤ 2**(ADDR_W-log2(NB))`.
- `LATENCY`, 2: accept-to-response latency in cycles (≥1).

Ports:
- `i_clk` in 1: clock.
- `i_rst_n` in 1: reset, synchronous, active-low. Clock `i_clk`.
- `i_req_valid` in `N_PORTS`: per-port request valid.
- `o_req_ready` in/out: out `N_PORTS`, per-port grant/ready.
- `i_req_addr` in `N_PORTS*ADDR_W`: byte addresses. Port p occupies `[p*ADDR_W +: ADDR_W]`.
- `i_req_wren` in `N_PORTS`: 1 = write, 0 = read.
- `i_req_wdata` in `N_PORTS*DATA_W`: write data.
- `i_req_bmask` in `N_PORTS*NB`: byte enables. Bit b covers `wdata[8b+:8]`.
- `o_rsp_valid` out `N_PORTS`: one-cycle response pulse.
- `o_rsp_rdata` out `N_PORTS*DATA_W`: read data. Valid only with `o_rsp_valid`.
- `o_rsp_err` out `N_PORTS`: out-of-range flag. Valid only with `o_rsp_valid`.

## Operation
- **Handshake.** A request is accepted in a cycle where `i_req_valid[p] & o_req_ready[p]`. At most one port is accepted per cycle.
  - The requester holds addr, wren, wdata and bmask stable while valid is high and not yet accepted.
  - Valid must not drop before acceptance.
- **Arbitration.** `o_req_ready` is a one-hot (or zero) combinational function of `i_req_valid` and the round-robin pointer `rr`.
  - The grant goes to the first valid port at or after `rr`, searching upward modulo `N_PORTS`.
  - On acceptance, `rr` becomes `(granted+1) mod N_PORTS`. With no valid request, `rr` holds.
  - `o_req_ready` is 0 for every port whose valid is 0.
- **Address decode.** Word index is `addr[ADDR_W-1:log2(NB)]`. The low `log2(NB)` bits are ignored (no misalignment check).
  - Out of range means index ≥ `DEPTH`.
- **Write.** On acceptance with `wren=1` and the index in range, each lane with a set bmask bit is updated at the accepting clock edge.
  - `bmask=0` is a legal no-op write.
  - If out of range, nothing is written.
- **Read.** With `wren=0`, the addressed word is sampled at the accepting edge. It reflects all writes accepted in earlier cycles.
- **Response.**
  - Every accepted request (read or write) yields exactly one response on the same port index.
  - `rdata` is the sampled word for an in-range read, and 0 for writes and out-of-range reads.
  - `err` is 1 iff the index is out of range.
  - There is no response backpressure: the requester must consume the pulse.
- **Pipeline.** A `LATENCY`-deep shift register carries {valid, port id, rdata, err}. Responses leave in acceptance order, at most one per cycle in total.
- **Memory contents** are not reset. The bench initialises them via writes.

## Timing
- **Reset.** While `i_rst_n=0` at a rising edge:
  - `rr` ← 0 and all response pipeline stages are cleared.
  - `o_rsp_valid`, `o_rsp_rdata` and `o_rsp_err` read 0 from the following cycle.
  - `o_req_ready` is all-zero during reset cycles, so no acceptance happens in reset.
- **Latency.** For a request accepted in cycle t, `o_rsp_valid[p]=1` in cycle t+`LATENCY` only.
  - Back-to-back acceptances in cycles t and t+1 give responses in cycles t+L and t+L+1.
- **Throughput.** One accept per cycle, sustained. A single port with valid held high is accepted every cycle.
- **Same-cycle contention.** All N ports valid gives grants in rotating order. Every port is served within `N_PORTS` cycles, so there is no starvation.
- **Read-after-write.** A write accepted in cycle t is visible to a read accepted in cycle t+1. The same-cycle case cannot occur.
- **Reset mid-operation.** In-flight responses are discarded and not replayed. Writes already accepted stay in memory.
- **Wrap.** `rr` wraps from `N_PORTS-1` to 0. Address index `DEPTH-1` is in range and `DEPTH` is an error.

## Test plan
- **Reset.** Hold `i_rst_n=0` for 3 cycles with all valids high.
  - Required: `o_req_ready=0`, `o_rsp_*=0` throughout.
  - Required: after release, port 0 is granted first.
- **Write/read, LATENCY=2.** Port 0 writes `0xDEADBEEF` to addr `0x10` with bmask `0xF` in cycle t. Port 0 then reads `0x10` in cycle t+1.
  - Required: the write response is at t+2 with rdata 0 and err 0.
  - Required: the read response is at t+3 with rdata `0xDEADBEEF`.
- **Byte mask.** Write `0x11223344` with bmask `0b0101` over an existing `0xAABBCCDD`. Then read the word.
  - Required: read returns `0xAA22CC44`.
- **Round-robin.** Both ports valid continuously for 6 cycles with reads.
  - Required: grant sequence 0,1,0,1,0,1.
  - Required: responses arrive on matching ports in the same order, each L cycles later.
- **Out of range, DEPTH=1024.** Write `0x12345678` to word 1024 (byte addr `0x1000`). Then read word 1023 and word 1024.
  - Required: the write reports err=1 and memory is unchanged.
  - Required: the word 1023 read gives err=0.
  - Required: the word 1024 read gives err=1 and rdata=0.
- **Reset in flight.** Accept a read, then assert reset in the next cycle.
  - Required: no `o_rsp_valid` appears.
  - Required: previously written data is still readable after reset.
